// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave Wishbone interconnect with a registered request stage,
// one-hot slave select, and bus errors for unmapped targets and slave timeouts.
module wb_interconnect_n #(
  parameter int unsigned NUM_SLAVES = 5,
  parameter int unsigned TID_W      = 3,
  parameter int unsigned TID_LSB    = 12,
  parameter int unsigned SLV_AW     = 12,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic [31:0]              m_wb_dat_i,
  input  logic [31:0]              m_wb_adr_i,
  input  logic [3:0]               m_wb_sel_i,
  input  logic                     m_wb_we_i,
  input  logic                     m_wb_cyc_i,
  input  logic                     m_wb_stb_i,
  output logic [31:0]              m_wb_dat_o,
  output logic                     m_wb_ack_o,
  output logic                     m_wb_err_o,
  output logic [31:0]              s_wb_dat_o,
  output logic [SLV_AW-1:0]        s_wb_adr_o,
  output logic [3:0]               s_wb_sel_o,
  output logic                     s_wb_we_o,
  output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
  input  logic [32*NUM_SLAVES-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, DERR, RESP} state_e;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_e                  state_q;
  logic [31:0]             s_dat_q;
  logic [SLV_AW-1:0]       s_adr_q;
  logic [3:0]              s_sel_q;
  logic                    s_we_q;
  logic [NUM_SLAVES-1:0]   cyc_q;
  logic [15:0]             cnt_q;
  logic [31:0]             m_dat_q;
  logic                    m_ack_q;
  logic                    m_err_q;

  logic [TID_W-1:0]        tid;
  logic [NUM_SLAVES-1:0]   hit_d;
  logic                    sel_ack;
  logic                    sel_err;
  logic [31:0]             sel_dat;
  logic                    unused_adr;

  assign unused_adr = ^m_wb_adr_i;

  // hit_d is all-zero for an unmapped target id, which routes the request to DERR.
  always_comb begin
    tid   = m_wb_adr_i[TID_LSB +: TID_W];
    hit_d = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      hit_d[i] = (tid == TID_W'(i));
    end
  end

  always_comb begin
    sel_ack = |(s_wb_ack_i & cyc_q);
    sel_err = |(s_wb_err_i & cyc_q);
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (cyc_q[i]) sel_dat = s_wb_dat_i[32*i +: 32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_dat_q <= '0;
      s_adr_q <= '0;
      s_sel_q <= '0;
      s_we_q  <= 1'b0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      m_dat_q <= '0;
      m_ack_q <= 1'b0;
      m_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m_ack_q <= 1'b0;
          m_err_q <= 1'b0;
          if (m_wb_cyc_i && m_wb_stb_i) begin
            s_dat_q <= m_wb_dat_i;
            s_adr_q <= {m_wb_adr_i[SLV_AW-1:2], 2'b00};
            s_sel_q <= m_wb_sel_i;
            s_we_q  <= m_wb_we_i;
            cyc_q   <= hit_d;
            cnt_q   <= '0;
            state_q <= (|hit_d) ? REQ : DERR;
          end
        end
        REQ: begin
          if (!m_wb_cyc_i) begin
            cyc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (sel_ack || sel_err) begin
            cyc_q   <= '0;
            m_dat_q <= sel_dat;
            m_ack_q <= sel_ack & ~sel_err;
            m_err_q <= sel_err;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
            // Timeout reuses DERR so the error lands TIMEOUT+2 cycles after the request.
            if (cnt_q == TO_LAST) begin
              cyc_q   <= '0;
              state_q <= DERR;
            end
          end
        end
        DERR: begin
          m_dat_q <= ERR_DATA;
          m_ack_q <= 1'b0;
          m_err_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          m_ack_q <= 1'b0;
          m_err_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_wb_dat_o = m_dat_q;
  assign m_wb_ack_o = m_ack_q;
  assign m_wb_err_o = m_err_q;
  assign s_wb_dat_o = s_dat_q;
  assign s_wb_adr_o = s_adr_q;
  assign s_wb_sel_o = s_sel_q;
  assign s_wb_we_o  = s_we_q;
  assign s_wb_cyc_o = cyc_q;
  assign s_wb_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Randomized bench for wb_interconnect_n: per-transaction outcome predicted from
// target id, slave response delay/kind, abort point and timeout.
module tb_wb_interconnect_n;

  localparam int NS    = 5;
  localparam int TW    = 3;
  localparam int TL    = 12;
  localparam int AW    = 12;
  localparam int TO    = 8;
  localparam int LIMIT = TO + 5;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic            clk;
  logic            rst_n;
  logic [31:0]     m_wb_dat_i, m_wb_adr_i, m_wb_dat_o;
  logic [3:0]      m_wb_sel_i;
  logic            m_wb_we_i, m_wb_cyc_i, m_wb_stb_i, m_wb_ack_o, m_wb_err_o;
  logic [31:0]     s_wb_dat_o;
  logic [AW-1:0]   s_wb_adr_o;
  logic [3:0]      s_wb_sel_o;
  logic            s_wb_we_o;
  logic [NS-1:0]   s_wb_cyc_o, s_wb_stb_o, s_wb_ack_i, s_wb_err_i;
  logic [32*NS-1:0] s_wb_dat_i;

  logic [31:0] sdat [NS];
  int n_cmp = 0;
  int n_bad = 0;

  wb_interconnect_n #(
    .NUM_SLAVES(NS), .TID_W(TW), .TID_LSB(TL), .SLV_AW(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_n(rst_n),
    .m_wb_dat_i(m_wb_dat_i), .m_wb_adr_i(m_wb_adr_i), .m_wb_sel_i(m_wb_sel_i),
    .m_wb_we_i(m_wb_we_i), .m_wb_cyc_i(m_wb_cyc_i), .m_wb_stb_i(m_wb_stb_i),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_ack_o(m_wb_ack_o), .m_wb_err_o(m_wb_err_o),
    .s_wb_dat_o(s_wb_dat_o), .s_wb_adr_o(s_wb_adr_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_we_o(s_wb_we_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m_wb_cyc_i = 1'b0;
    m_wb_stb_i = 1'b0;
    m_wb_we_i  = 1'b0;
    m_wb_sel_i = '0;
    m_wb_adr_i = '0;
    m_wb_dat_i = '0;
    s_wb_ack_i = '0;
    s_wb_err_i = '0;
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 never responds. d = sample index of slave response.
  // Abort: master drops cyc at sample a. Must be called just after a falling clock edge.
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int d, input int kind,
                        input bit abort_en, input int a);
    int tid = int'(adr[TL +: TW]);
    bit mapped = (tid < NS);
    int resp_d = (kind == 3) ? 1000000 : d;
    logic [31:0] exp_bits = mapped ? (32'd1 << tid) : 32'd0;
    int exp_cyc, exp_at, exp_cnt;
    logic [31:0] exp_kind, exp_dat;
    bit chk_dat = 1'b0;
    logic [NS-1:0] stb_or = '0;
    int stb_cyc = 0, multi = 0, cycdiff = 0, resp_cnt = 0, resp_at = -1;
    logic [31:0] resp_kind = '0, got_dat = '0;
    logic [31:0] c_adr = 'x, c_we = 'x, c_sel = 'x, c_dat = 'x;
    bit seen = 1'b0;

    exp_kind = 32'd0;
    exp_dat  = DEAD;
    if (!mapped) begin
      exp_cyc = 0; exp_cnt = 1; exp_at = 1; exp_kind = 32'd2; chk_dat = 1'b1;
    end else if (abort_en && a <= resp_d && a <= TO - 1) begin
      exp_cyc = a + 1; exp_cnt = 0; exp_at = -1;
    end else if (resp_d <= TO - 1) begin
      exp_cyc = d + 1; exp_cnt = 1; exp_at = d + 1;
      exp_kind = (kind == 0) ? 32'd1 : 32'd2;
      exp_dat  = sdat[0];
      chk_dat  = 1'b0;
    end else begin
      exp_cyc = TO; exp_cnt = 1; exp_at = TO + 1; exp_kind = 32'd2; chk_dat = 1'b1;
    end

    for (int i = 0; i < NS; i++) begin
      sdat[i] = $urandom;
      s_wb_dat_i[32*i +: 32] = sdat[i];
    end
    if (mapped && exp_cnt == 1 && kind == 0 && !we && resp_d <= TO - 1) begin
      exp_dat = sdat[tid];
      chk_dat = 1'b1;
    end

    m_wb_adr_i = adr; m_wb_we_i = we; m_wb_dat_i = wdat; m_wb_sel_i = sel;
    m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1;

    for (int s = 0; s < LIMIT; s++) begin
      @(negedge clk);
      if (s_wb_stb_o != '0) begin
        if (!seen) begin
          seen = 1'b1;
          c_adr = 32'(s_wb_adr_o); c_we = 32'(s_wb_we_o);
          c_sel = 32'(s_wb_sel_o); c_dat = s_wb_dat_o;
        end
        stb_cyc++;
        stb_or |= s_wb_stb_o;
        if ((s_wb_stb_o & (s_wb_stb_o - 1'b1)) != '0) multi++;
      end
      if (s_wb_cyc_o !== s_wb_stb_o) cycdiff++;
      if (m_wb_ack_o || m_wb_err_o) begin
        resp_cnt++;
        if (resp_at < 0) begin
          resp_at   = s;
          resp_kind = {30'd0, m_wb_err_o, m_wb_ack_o};
          got_dat   = m_wb_dat_o;
        end
        m_wb_cyc_i = 1'b0;
        m_wb_stb_i = 1'b0;
      end
      s_wb_ack_i = '0;
      s_wb_err_i = '0;
      for (int j = 0; j < NS; j++) begin
        if (j != tid && $urandom_range(0, 3) == 0) begin
          s_wb_ack_i[j] = 1'($urandom_range(0, 1));
          s_wb_err_i[j] = 1'($urandom_range(0, 1));
        end
      end
      if (mapped && kind != 3 && s == d && s_wb_stb_o[tid]) begin
        s_wb_ack_i[tid] = (kind == 0 || kind == 2);
        s_wb_err_i[tid] = (kind == 1 || kind == 2);
      end
      if (abort_en && s == a) begin
        m_wb_cyc_i = 1'b0;
        m_wb_stb_i = 1'b0;
      end
    end
    idle_inputs();

    check_eq("stb_bits", 32'(stb_or), exp_bits);
    check_eq("stb_cycles", stb_cyc, exp_cyc);
    check_eq("stb_multi", multi, 0);
    check_eq("cyc_eq_stb", cycdiff, 0);
    check_eq("resp_count", resp_cnt, exp_cnt);
    if (exp_cnt == 1) begin
      check_eq("resp_at", resp_at, exp_at);
      check_eq("resp_kind", resp_kind, exp_kind);
    end
    if (chk_dat) check_eq("rdata", got_dat, exp_dat);
    if (mapped) begin
      check_eq("s_adr", c_adr, 32'({adr[AW-1:2], 2'b00}));
      check_eq("s_we", c_we, 32'(we));
      check_eq("s_sel", c_sel, 32'(sel));
      if (we) check_eq("s_wdat", c_dat, wdat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    s_wb_dat_i = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_m_dat", m_wb_dat_o, 32'd0);
    check_eq("rst_m_resp", {30'd0, m_wb_err_o, m_wb_ack_o}, 32'd0);
    check_eq("rst_s_stb", 32'({s_wb_cyc_o, s_wb_stb_o}), 32'd0);
    check_eq("rst_s_bus", s_wb_dat_o | 32'(s_wb_adr_o) | 32'(s_wb_sel_o) | 32'(s_wb_we_o), 32'd0);
    rst_n = 1'b1;

    do_txn(32'h0000_2004, 1'b0, 32'd0,         4'hF,    1, 0, 1'b0, 0);
    do_txn(32'h0000_4010, 1'b1, 32'hA5A5_A5A5, 4'b0011, 0, 0, 1'b0, 0);
    do_txn(32'h0000_7000, 1'b0, 32'd0,         4'hF,    0, 0, 1'b0, 0);
    do_txn(32'h0000_1000, 1'b0, 32'd0,         4'hF,    0, 3, 1'b0, 0);
    do_txn(32'h0000_0000, 1'b0, 32'd0,         4'hF,    0, 3, 1'b1, 3);
    do_txn(32'h0000_1000, 1'b0, 32'd0,         4'hF,    2, 0, 1'b0, 0);
    do_txn(32'h0000_0008, 1'b0, 32'd0,         4'hF,    0, 0, 1'b0, 0);
    do_txn(32'h0000_3008, 1'b0, 32'd0,         4'hF,    0, 0, 1'b0, 0);
    do_txn(32'h0000_300C, 1'b0, 32'd0,         4'hF,    2, 2, 1'b0, 0);
    do_txn(32'h0000_2000, 1'b0, 32'd0,         4'hF, TO-1, 0, 1'b0, 0);
    do_txn(32'h0000_2000, 1'b0, 32'd0,         4'hF,   TO, 0, 1'b0, 0);
    do_txn(32'h0000_4000, 1'b0, 32'd0,         4'hF,    2, 0, 1'b1, 2);
    do_txn(32'hFFFF_0FFC, 1'b1, 32'h0BAD_F00D, 4'h8,    1, 1, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      do_txn($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
             int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 5) == 0), int'($urandom_range(0, TO)));
    end

    // Asynchronous reset in the middle of a pending write to slave 3.
    m_wb_adr_i = 32'h0000_3ABC; m_wb_dat_i = 32'hCAFE_0001; m_wb_sel_i = 4'hF;
    m_wb_we_i = 1'b1; m_wb_cyc_i = 1'b1; m_wb_stb_i = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_stb", 32'(s_wb_stb_o), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_stb", 32'({s_wb_cyc_o, s_wb_stb_o}), 32'd0);
    check_eq("arst_bus", s_wb_dat_o | 32'(s_wb_adr_o) | 32'(s_wb_sel_o) | 32'(s_wb_we_o), 32'd0);
    check_eq("arst_m", m_wb_dat_o | {30'd0, m_wb_err_o, m_wb_ack_o}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(32'h0000_3ABC, 1'b0, 32'd0, 4'hF, 0, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_n.md
Name: wb_interconnect_n

Overview:
- Parametrised single-master, N-slave Wishbone interconnect with registered staging between the master and the selected slave.
- Decodes a target id from a configurable address field and routes the staged request to one slave, using one-hot cyc/stb.
- Returns the selected slave's read data and ack to the master.
- Adds bus-error generation for two cases: unmapped target ids, and slaves that do not ack before a timeout.

Parameters:
- NUM_SLAVES, 5, number of slave ports (1..2**TID_W).
- TID_W, 3, width of the target-id field.
- TID_LSB, 12, bit position of the target-id LSB in m_wb_adr_i.
- SLV_AW, 12, address width broadcast to the slaves (adr[SLV_AW-1:0], word-aligned).
- TIMEOUT, 255, cycles the interconnect waits for a slave ack before it returns an error (1..65535).

Ports:
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_wb_dat_i  in  32  master write data.
- m_wb_adr_i  in  32  master byte address.
- m_wb_sel_i  in  4  byte selects.
- m_wb_we_i  in  1  write enable.
- m_wb_cyc_i  in  1  cycle.
- m_wb_stb_i  in  1  strobe.
- m_wb_dat_o  out  32  read data to master.
- m_wb_ack_o  out  1  ack to master.
- m_wb_err_o  out  1  bus error to master.
- s_wb_dat_o  out  32  staged write data, broadcast to all slaves.
- s_wb_adr_o  out  SLV_AW  staged address, bits [1:0] forced to 0, broadcast.
- s_wb_sel_o  out  4  staged byte selects, broadcast.
- s_wb_we_o  out  1  staged write enable, broadcast.
- s_wb_cyc_o  out  NUM_SLAVES  one-hot cycle, bit i drives slave i.
- s_wb_stb_o  out  NUM_SLAVES  one-hot strobe.
- s_wb_dat_i  in  32*NUM_SLAVES  slave read data; slave i uses bits [32*i+31:32*i].
- s_wb_ack_i  in  NUM_SLAVES  slave acks.
- s_wb_err_i  in  NUM_SLAVES  slave errors.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Every output is 0: m_wb_dat_o, m_wb_ack_o, m_wb_err_o, all s_wb_* outputs.
  - FSM = IDLE; timeout counter = 0.
- Target id: tid = m_wb_adr_i[TID_LSB +: TID_W]. Address bits above the field are ignored.
- FSM states: IDLE, REQ, DERR, RESP.
- IDLE:
  - On m_wb_cyc_i & m_wb_stb_i, register dat, adr, sel, we and tid.
  - tid < NUM_SLAVES -> REQ. s_wb_cyc_o[tid] and s_wb_stb_o[tid] are asserted from the next cycle.
  - tid >= NUM_SLAVES -> DERR. No slave strobe is asserted.
- REQ:
  - Holds the staged request stable; the counter increments each cycle.
  - Selected slave ack or err sampled high:
    - Capture that slave's dat_i, ack and err.
    - Drop cyc/stb on the next edge and go to RESP.
    - If ack and err are both high, err wins and ack is 0.
  - Counter reaches TIMEOUT with no response:
    - Drop the slave cyc/stb, capture error, go to RESP.
    - m_wb_dat_o = 0xDEAD_BEEF.
  - m_wb_cyc_i falls (master abort):
    - Drop slave cyc/stb on the next edge and return to IDLE.
    - No master ack or err is issued.
    - A slave ack arriving in the same cycle as the abort is discarded.
- DERR: one cycle, then RESP with err = 1 and m_wb_dat_o = 0xDEAD_BEEF.
- RESP:
  - Exactly one cycle with m_wb_ack_o or m_wb_err_o high (never both).
  - m_wb_dat_o is valid in this cycle and holds its last value afterwards.
  - Returns to IDLE; the counter clears.
  - A new request is accepted no earlier than the cycle after RESP. Classic Wishbone: the master drops stb after sampling ack.
- Latency:
  - Master stb sampled at edge 0 -> slave stb high after edge 0.
  - Zero-wait slave acks in that cycle -> master ack high in the cycle after the slave ack (2 cycles from request to master ack).
  - Unmapped tid -> err 2 cycles after request.
  - Timeout -> err after TIMEOUT+2 cycles.
- Only one slave cyc/stb bit is ever high. Acks from unselected slaves are ignored.
- Writes follow the same flow; m_wb_dat_o is don't-care on write acks.
- Reset asserted mid-transaction: everything clears immediately, asynchronously. The pending transaction is lost and no ack is issued.

Test Plan:
- Read 0x0000_2004, slave 2 acks one cycle after its stb with 0x1234_5678:
  - s_wb_stb_o = 5'b00100, s_wb_adr_o = 0x004.
  - m_wb_ack_o pulses once with m_wb_dat_o = 0x1234_5678.
- Write 0x0000_4010 with data 0xA5A5_A5A5, sel 4'b0011:
  - slave 4 sees we = 1, adr 0x010, sel 0x3, dat 0xA5A5_A5A5.
  - Single master ack; no other slave strobed.
- Access 0x0000_7000 (tid 7 >= 5):
  - No s_wb_stb_o bit rises.
  - m_wb_err_o pulses 2 cycles after request, m_wb_dat_o = 0xDEAD_BEEF.
- TIMEOUT = 8, slave 1 never acks:
  - s_wb_stb_o[1] high for 8 cycles then drops.
  - m_wb_err_o pulses at request + 10 cycles.
- Master drops cyc 3 cycles into a slave-0 wait:
  - slave 0 strobe drops the next cycle; no master ack or err.
  - A following request to 0x0000_1000 completes normally.
- Back-to-back reads to slaves 0 then 3:
  - Both complete with correct data, strobes never overlap.
- Assert rst_n low during REQ: all outputs 0 asynchronously, FSM = IDLE after release.
